// File: rtl/data_mem_responder_if.sv
// CPU-side request/response bus of the data memory responder.
// The master drives the request fields; the slave returns status and read data.
interface data_mem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        ready;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, addr, wdata,
    input  busy, ready, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output busy, ready, rdata, err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Single-ported 32-bit data memory with a fixed request-to-response latency.
// One request is outstanding at a time; a new one may be accepted in the response cycle.
module data_mem_responder #(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned DEPTH   = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  data_mem_responder_if.slave   bus
);

  localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  // state | meaning
  // IDLE  | no request outstanding, accepts req
  // WAIT  | request captured, latency counter running, req ignored
  // RESP  | ready pulse with rdata/err, accepts req back-to-back
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0]     mem_q [DEPTH];
  // Words never written read back their power-up pattern (index + 10); rst does not touch this.
  logic [DEPTH-1:0] written_q = '0;

  logic          mem_we;
  logic          in_range;
  logic [AW-1:0] idx;
  logic [31:0]   rd_word;

  assign idx      = addr_q[AW-1:0];
  assign in_range = (addr_q < 32'(DEPTH));
  assign rd_word  = written_q[idx] ? mem_q[idx] : (32'(idx) + 32'd10);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (bus.req) begin
          state_d = ST_WAIT;
          cnt_d   = LAT_M1;
          we_d    = bus.we;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          if (in_range) begin
            if (we_q) mem_we  = 1'b1;
            else      rdata_d = rd_word;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // An abort by rst leaves WAIT before this edge, so mem_we cannot fire for it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx]     <= wdata_q;
      written_q[idx] <= 1'b1;
    end
  end

  assign bus.busy  = (state_q == ST_WAIT);
  assign bus.ready = (state_q == ST_RESP);
  assign bus.err   = (state_q == ST_RESP) && !in_range;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: LATENCY=2 and LATENCY=1 instances, expected
// responses queued at request time and compared when ready pulses.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;

  data_mem_responder_if bus0();
  data_mem_responder_if bus1();

  data_mem_responder #(.LATENCY(2), .DEPTH(256)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  data_mem_responder #(.LATENCY(1), .DEPTH(256)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int   checks = 0;
  int   errors = 0;
  int   resp0  = 0;
  int   resp1  = 0;

  always @(negedge clk) begin
    checks++;
    if (bus0.ready) begin
      resp0++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL resp0_unexpected: ready=1 rdata=%h err=%b, required no response", bus0.rdata, bus0.err);
      end else begin
        e0 = q0.pop_front();
        if (bus0.rdata !== e0.rdata || bus0.err !== e0.err) begin
          errors++;
          $display("FAIL resp0_data: rdata=%h err=%b, required rdata=%h err=%b", bus0.rdata, bus0.err, e0.rdata, e0.err);
        end
      end
    end else if (bus0.err !== 1'b0) begin
      errors++;
      $display("FAIL err0_outside_resp: err=%b, required 0", bus0.err);
    end
  end

  always @(negedge clk) begin
    checks++;
    if (bus1.ready) begin
      resp1++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL resp1_unexpected: ready=1 rdata=%h err=%b, required no response", bus1.rdata, bus1.err);
      end else begin
        e1 = q1.pop_front();
        if (bus1.rdata !== e1.rdata || bus1.err !== e1.err) begin
          errors++;
          $display("FAIL resp1_data: rdata=%h err=%b, required rdata=%h err=%b", bus1.rdata, bus1.err, e1.rdata, e1.err);
        end
      end
    end else if (bus1.err !== 1'b0) begin
      errors++;
      $display("FAIL err1_outside_resp: err=%b, required 0", bus1.err);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Drive one request on bus0 once it can be accepted; request fields are scrambled afterwards.
  task automatic issue0(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rdata, input logic exp_err);
    int n = 0;
    while (bus0.busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus0.busy) begin
      checks++;
      errors++;
      $display("FAIL issue0_timeout: busy=%b, required 0 within 50 cycles", bus0.busy);
    end
    bus0.req   = 1'b1;
    bus0.we    = w;
    bus0.addr  = a;
    bus0.wdata = d;
    q0.push_back('{rdata: exp_rdata, err: exp_err});
    @(negedge clk);
    bus0.req   = 1'b0;
    bus0.we    = 1'($urandom);
    bus0.addr  = $urandom;
    bus0.wdata = $urandom;
  endtask

  task automatic wait0();
    int n = 0;
    while (q0.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q0.size() != 0) begin
      errors++;
      $display("FAIL wait0_timeout: outstanding=%0d, required 0", q0.size());
      q0.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = 32'd0; bus0.wdata = 32'd0;
    bus1.req = 1'b0; bus1.we = 1'b0; bus1.addr = 32'd0; bus1.wdata = 32'd0;
    #1 rst = 1'b1;
    #2;
    checks++;
    if ({bus0.busy, bus0.ready, bus0.err} !== 3'b000 || bus0.rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset0: busy/ready/err=%b rdata=%h, required 000 and 0", {bus0.busy, bus0.ready, bus0.err}, bus0.rdata);
    end
    checks++;
    if ({bus1.busy, bus1.ready, bus1.err} !== 3'b000 || bus1.rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset1: busy/ready/err=%b rdata=%h, required 000 and 0", {bus1.busy, bus1.ready, bus1.err}, bus1.rdata);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_read_after_reset();
    logic [3:0] exp_busy  = 4'b0011;
    logic [3:0] exp_ready = 4'b0100;
    bus0.req  = 1'b1;
    bus0.we   = 1'b0;
    bus0.addr = 32'd1;
    q0.push_back('{rdata: 32'h0000000B, err: 1'b0});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus0.req  = 1'b0;
      bus0.addr = $urandom;
      checks++;
      if (bus0.busy !== exp_busy[i] || bus0.ready !== exp_ready[i]) begin
        errors++;
        $display("FAIL read_timing[%0d]: busy=%b ready=%b, required busy=%b ready=%b",
                 i, bus0.busy, bus0.ready, exp_busy[i], exp_ready[i]);
      end
      if (exp_ready[i]) begin
        checks++;
        if (bus0.rdata !== 32'h0000000B || bus0.err !== 1'b0) begin
          errors++;
          $display("FAIL read_addr1: rdata=%h err=%b, required 0000000b err=0", bus0.rdata, bus0.err);
        end
      end
    end
    wait0();
  endtask

  task automatic test_write_read();
    int n = 0;
    issue0(1'b1, 32'd5, 32'hDEADBEEF, 32'h0000000B, 1'b0);
    while (!bus0.ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus0.ready !== 1'b1 || bus0.busy !== 1'b0) begin
      errors++;
      $display("FAIL write_resp_cycle: ready=%b busy=%b, required ready=1 busy=0", bus0.ready, bus0.busy);
    end
    issue0(1'b0, 32'd5, 32'd0, 32'hDEADBEEF, 1'b0);
    issue0(1'b0, 32'd6, 32'd0, 32'h00000010, 1'b0);
    wait0();
  endtask

  task automatic test_out_of_range();
    issue0(1'b0, 32'h00000100, 32'd0, 32'h00000010, 1'b1);
    issue0(1'b1, 32'h00000100, 32'h12345678, 32'h00000010, 1'b1);
    issue0(1'b0, 32'h00000000, 32'd0, 32'h0000000A, 1'b0);
    issue0(1'b0, 32'h80000003, 32'd0, 32'h0000000A, 1'b1);
    wait0();
  endtask

  task automatic test_busy_ignore();
    int start = resp0;
    bus0.req  = 1'b1;
    bus0.we   = 1'b0;
    bus0.addr = 32'd2;
    q0.push_back('{rdata: 32'h0000000C, err: 1'b0});
    @(negedge clk);
    checks++;
    if (bus0.busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_wait1: busy=%b, required 1", bus0.busy);
    end
    bus0.addr  = 32'd3;
    bus0.we    = 1'b1;
    bus0.wdata = $urandom;
    @(negedge clk);
    checks++;
    if (bus0.busy !== 1'b1 || bus0.ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_wait2: busy=%b ready=%b, required busy=1 ready=0", bus0.busy, bus0.ready);
    end
    bus0.we = 1'b0;
    @(negedge clk);
    checks++;
    if (bus0.ready !== 1'b1 || bus0.busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_resp: ready=%b busy=%b, required ready=1 busy=0", bus0.ready, bus0.busy);
    end
    q0.push_back('{rdata: 32'h0000000D, err: 1'b0});
    @(negedge clk);
    bus0.req = 1'b0;
    wait0();
    checks++;
    if (resp0 - start != 2) begin
      errors++;
      $display("FAIL busy_resp_count: responses=%0d, required 2", resp0 - start);
    end
  endtask

  task automatic test_reset_mid();
    bus0.req   = 1'b1;
    bus0.we    = 1'b1;
    bus0.addr  = 32'd7;
    bus0.wdata = 32'hCAFEF00D;
    @(negedge clk);
    bus0.req = 1'b0;
    checks++;
    if (bus0.busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre: busy=%b, required 1", bus0.busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus0.busy, bus0.ready, bus0.err} !== 3'b000 || bus0.rdata !== 32'd0) begin
      errors++;
      $display("FAIL abort_async: busy/ready/err=%b rdata=%h, required 000 and 0", {bus0.busy, bus0.ready, bus0.err}, bus0.rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    bus0.req  = 1'b1;
    bus0.we   = 1'b0;
    bus0.addr = 32'd7;
    q0.push_back('{rdata: 32'h00000011, err: 1'b0});
    @(negedge clk);
    bus0.req = 1'b0;
    wait0();
  endtask

  task automatic test_latency1();
    logic [6:0] pat = 7'b0101010;
    int start = resp1;
    bus1.req  = 1'b1;
    bus1.we   = 1'b0;
    bus1.addr = 32'd0;
    q1.push_back('{rdata: 32'h0000000A, err: 1'b0});
    q1.push_back('{rdata: 32'h0000000B, err: 1'b0});
    q1.push_back('{rdata: 32'h0000000C, err: 1'b0});
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checks++;
      if (bus1.ready !== pat[i]) begin
        errors++;
        $display("FAIL lat1_ready[%0d]: ready=%b, required %b", i + 1, bus1.ready, pat[i]);
      end
      if (i == 0) bus1.addr = 32'd1;
      if (i == 2) bus1.addr = 32'd2;
      if (i == 4) bus1.req  = 1'b0;
    end
    checks++;
    if (resp1 - start != 3 || q1.size() != 0) begin
      errors++;
      $display("FAIL lat1_count: responses=%0d outstanding=%0d, required 3 and 0", resp1 - start, q1.size());
    end
  endtask

  initial begin
    test_reset();
    test_read_after_reset();
    test_write_read();
    test_out_of_range();
    test_busy_ignore();
    test_reset_mid();
    test_latency1();
    for (int i = 0; i < 5; i++) @(negedge clk);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL final_queues: outstanding=%0d/%0d, required 0/0", q0.size(), q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter LATENCY, default 2, gives the number of cycles from request acceptance to response (legal range 1..15).
REQ-002 Parameter DEPTH, default 256, gives the number of 32-bit words.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state changes on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port req, input, 1 bit: request strobe from the CPU side.
REQ-006 The block SHALL have port we, input, 1 bit: 1 = write, 0 = read, sampled with req.
REQ-007 The block SHALL have port addr, input, 32 bits: word address (word index, not byte address).
REQ-008 The block SHALL have port wdata, input, 32 bits: write data, sampled with req.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a request is outstanding and no new request can be accepted.
REQ-010 The block SHALL have port ready, output, 1 bit: one-cycle response pulse.
REQ-011 The block SHALL have port rdata, output, 32 bits: read data, valid when ready=1 for a read.
REQ-012 The block SHALL have port err, output, 1 bit: out-of-range flag, valid with ready.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-014 In IDLE or RESP, req=1 at a rising edge SHALL accept the request, capture we/addr/wdata into internal registers, load the counter with LATENCY-1, and enter WAIT.
REQ-015 In WAIT, req SHALL be ignored, with no capture and no queuing.
REQ-016 In WAIT, at each edge, a counter value of 0 SHALL perform the access and enter RESP; otherwise the counter SHALL decrement.
REQ-017 busy SHALL be 1 exactly in WAIT, and 0 in IDLE and RESP.
REQ-018 ready SHALL be 1 exactly in RESP: one cycle, first high LATENCY cycles after the accepting edge.
REQ-019 RESP with no req SHALL return to IDLE, and RESP with req SHALL accept back-to-back per REQ-014, giving a sustained throughput of one access per LATENCY+1 cycles.
REQ-020 The in-range condition SHALL be captured addr[31:8]==0 (for DEPTH=256); the memory index SHALL be the captured addr[7:0].
REQ-021 For an in-range write, mem[index] SHALL be updated with the captured wdata at the edge entering RESP; rdata SHALL be unchanged.
REQ-022 For an in-range read, rdata SHALL be loaded with mem[index] at the edge entering RESP, and SHALL hold until the next completed read.
REQ-023 For an out-of-range request, there SHALL be no memory write, rdata SHALL be unchanged, and err=1 SHALL be asserted during RESP.
REQ-024 err SHALL be 0 at all times except a RESP cycle of an out-of-range request.
REQ-025 A read completing after a write to the same index SHALL return the written value (the write is committed before any later access).
REQ-026 Memory contents SHALL initialise at time zero to mem[i] = i + 10 (32-bit) and SHALL NOT be affected by rst.
REQ-027 Input values of we/addr/wdata outside the accepting edge SHALL have no effect.

Reset
REQ-028 rst=1 SHALL force, immediately and independently of clk: state to IDLE, counter=0, busy=0, ready=0, err=0, rdata=0.
REQ-029 rst asserted in WAIT SHALL abort the outstanding request: no memory write and no ready pulse, ever.
REQ-030 The first edge with rst=0 and req=1 SHALL accept a request normally.

Verification
REQ-031 The bench SHALL cover a read after reset with LATENCY=2: req=1, we=0, addr=1 at edge E0 -> busy=1 for 2 cycles, ready=1 and rdata=0x0000000B in the cycle after E2, err=0.
REQ-032 The bench SHALL cover write then read: write 0xDEADBEEF to addr 5, then read addr 5 accepted in the write's RESP cycle -> read returns 0xDEADBEEF; a read of addr 6 returns 0x00000010.
REQ-033 The bench SHALL cover out of range: read addr 0x00000100 -> ready=1, err=1, rdata unchanged; write addr 0x00000100 with 0x12345678 -> err=1, and a subsequent read of addr 0 returns 0x0000000A.
REQ-034 The bench SHALL cover requests while busy: req held high through WAIT with addr changing 2->3 -> exactly one response per acceptance, with the data of the captured address.
REQ-035 The bench SHALL cover reset mid-operation: write 0xCAFEF00D to addr 7, rst pulsed in WAIT -> no ready pulse, and a later read of addr 7 returns 0x00000011.
REQ-036 The bench SHALL cover LATENCY=1: back-to-back reads of addr 0, 1, 2 with req held high -> ready pulses every 2 cycles with rdata 0x0A, 0x0B, 0x0C.
